// File: rtl/insn_decode_queue.sv
// Buffered RVV instruction decoder: FIFO plus a registered decode stage with valid/ready on both sides.
// Build option INSN_DECODE_ILLEGAL_FLAG_EN: queue illegal encodings and flag them instead of dropping them.
module insn_decode_queue #(
  parameter int INSN_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          flush_i,
  input  logic [INSN_WIDTH-1:0]         insn_i,
  input  logic                          insn_valid_i,
  output logic                          insn_ready_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [6:0]                    opcode_mjr_o,
  output logic [2:0]                    opcode_mnr_o,
  output logic [4:0]                    dest_o,
  output logic [4:0]                    src_1_o,
  output logic [4:0]                    src_2_o,
  output logic [2:0]                    width_o,
  output logic [1:0]                    mop_o,
  output logic                          mew_o,
  output logic [2:0]                    nf_o,
  output logic [10:0]                   vtype_11_o,
  output logic [9:0]                    vtype_10_o,
  output logic [1:0]                    cfg_type_o,
  output logic                          vm_o,
  output logic [5:0]                    funct6_o,
  output logic [1:0]                    insn_class_o,
  output logic                          illegal_o,
  output logic [$clog2(DEPTH+2)-1:0]    occupancy_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int OCC_W = $clog2(DEPTH+2);

  function automatic logic is_illegal(input logic [31:0] insn);
    logic bad;
    bad = 1'b1;
    case (insn[6:0])
      7'h57:        bad = 1'b0;
      7'h07, 7'h27: bad = !(insn[14:12] inside {3'd0, 3'd5, 3'd6, 3'd7});
      default:      bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [1:0] classify(input logic [31:0] insn);
    logic [1:0] cls;
    cls = 2'd0;
    case (insn[6:0])
      7'h57:   cls = (insn[14:12] == 3'b111) ? 2'd3 : 2'd0;
      7'h07:   cls = 2'd1;
      7'h27:   cls = 2'd2;
      default: cls = 2'd0;
    endcase
    if (is_illegal(insn)) cls = 2'd0;
    return cls;
  endfunction

  logic [INSN_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  out_valid_q, out_valid_d;
  logic [31:0]           out_insn_q, out_insn_d;
  logic [1:0]            out_class_q, out_class_d;
  logic                  accept, keep, pop, load_out, push, fifo_pop;
  logic [31:0]           head_insn;

  assign insn_ready_o = (count_q != CNT_W'(DEPTH)) && rst_n_i;
  assign accept       = insn_valid_i && insn_ready_o;
  assign pop          = out_valid_q && out_ready_i;
  assign load_out     = !out_valid_q || pop;
  assign head_insn    = mem_q[rd_ptr_q];

`ifdef INSN_DECODE_ILLEGAL_FLAG_EN
  logic out_illegal_q, out_illegal_d;
  assign keep      = accept;
  assign illegal_o = out_illegal_q;
`else
  // Illegal encodings complete the handshake but are never stored.
  assign keep      = accept && !is_illegal(insn_i);
  assign illegal_o = 1'b0;
`endif

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_insn_d  = out_insn_q;
    out_class_d = out_class_q;
`ifdef INSN_DECODE_ILLEGAL_FLAG_EN
    out_illegal_d = out_illegal_q;
`endif
    fifo_pop    = 1'b0;
    if (load_out) begin
      if (count_q != '0) begin
        out_valid_d = 1'b1;
        out_insn_d  = head_insn;
        out_class_d = classify(head_insn);
`ifdef INSN_DECODE_ILLEGAL_FLAG_EN
        out_illegal_d = is_illegal(head_insn);
`endif
        fifo_pop    = 1'b1;
        rd_ptr_d    = rd_ptr_q + PTR_W'(1);
      end else if (keep) begin
        out_valid_d = 1'b1;
        out_insn_d  = insn_i;
        out_class_d = classify(insn_i);
`ifdef INSN_DECODE_ILLEGAL_FLAG_EN
        out_illegal_d = is_illegal(insn_i);
`endif
      end else begin
        out_valid_d = 1'b0;
      end
    end
    push = keep && !(load_out && (count_q == '0));
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(fifo_pop);
    // Flush wins over any accept or pop in the same cycle.
    if (flush_i) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
      push        = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_insn_q  <= '0;
      out_class_q <= '0;
`ifdef INSN_DECODE_ILLEGAL_FLAG_EN
      out_illegal_q <= 1'b0;
`endif
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_insn_q  <= out_insn_d;
      out_class_q <= out_class_d;
`ifdef INSN_DECODE_ILLEGAL_FLAG_EN
      out_illegal_q <= out_illegal_d;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= insn_i;
  end

  assign out_valid_o  = out_valid_q;
  assign insn_class_o = out_class_q;
  assign occupancy_o  = OCC_W'(count_q) + OCC_W'(out_valid_q);
  assign opcode_mjr_o = out_insn_q[6:0];
  assign opcode_mnr_o = out_insn_q[14:12];
  assign width_o      = out_insn_q[14:12];
  assign dest_o       = out_insn_q[11:7];
  assign src_1_o      = out_insn_q[19:15];
  assign src_2_o      = out_insn_q[24:20];
  assign vm_o         = out_insn_q[25];
  assign funct6_o     = out_insn_q[31:26];
  assign vtype_11_o   = out_insn_q[30:20];
  assign vtype_10_o   = out_insn_q[29:20];
  assign mop_o        = out_insn_q[27:26];
  assign mew_o        = out_insn_q[28];
  assign nf_o         = out_insn_q[31:29];
  assign cfg_type_o   = out_insn_q[31:30];

endmodule

// File: tb/tb_insn_decode_queue.sv
// Bench for insn_decode_queue: directed steps plus random traffic against a queue-based reference.
module tb_insn_decode_queue;
  localparam int DEPTH = 4;
`ifdef INSN_DECODE_ILLEGAL_FLAG_EN
  localparam bit FLAG_EN = 1'b1;
`else
  localparam bit FLAG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, flush, insn_valid, insn_ready, out_valid, out_ready;
  logic [31:0] insn;
  logic [6:0]  opcode_mjr;
  logic [2:0]  opcode_mnr, width, nf;
  logic [4:0]  dest, src_1, src_2;
  logic [1:0]  mop, cfg_type, insn_class;
  logic        mew, vm, illegal;
  logic [10:0] vtype_11;
  logic [9:0]  vtype_10;
  logic [5:0]  funct6;
  logic [$clog2(DEPTH+2)-1:0] occupancy;

  int errs = 0;
  int checks = 0;
  logic [31:0] mq[$];

  always #5 clk = ~clk;

  insn_decode_queue #(.INSN_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .insn_i(insn),
    .insn_valid_i(insn_valid), .insn_ready_o(insn_ready),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .opcode_mjr_o(opcode_mjr), .opcode_mnr_o(opcode_mnr), .dest_o(dest),
    .src_1_o(src_1), .src_2_o(src_2), .width_o(width), .mop_o(mop),
    .mew_o(mew), .nf_o(nf), .vtype_11_o(vtype_11), .vtype_10_o(vtype_10),
    .cfg_type_o(cfg_type), .vm_o(vm), .funct6_o(funct6),
    .insn_class_o(insn_class), .illegal_o(illegal), .occupancy_o(occupancy)
  );

  function automatic bit m_illegal(input logic [31:0] x);
    if (x[6:0] == 7'h57) return 1'b0;
    if (x[6:0] == 7'h07 || x[6:0] == 7'h27)
      return !(x[14:12] == 3'd0 || x[14:12] == 3'd5 || x[14:12] == 3'd6 || x[14:12] == 3'd7);
    return 1'b1;
  endfunction

  function automatic logic [1:0] m_class(input logic [31:0] x);
    if (m_illegal(x)) return 2'd0;
    if (x[6:0] == 7'h07) return 2'd1;
    if (x[6:0] == 7'h27) return 2'd2;
    return (x[14:12] == 3'b111) ? 2'd3 : 2'd0;
  endfunction

  function automatic logic [63:0] m_fields(input logic [31:0] x);
    return {x[6:0], x[14:12], x[11:7], x[19:15], x[24:20], x[14:12], x[27:26], x[28],
            x[31:29], x[30:20], x[29:20], x[31:30], x[25], x[31:26]};
  endfunction

  function automatic logic [31:0] rand_legal();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: begin r[6:0] = 7'h57; if (r[14:12] == 3'b111) r[14:12] = 3'b000; end
      1: begin r[6:0] = 7'h57; r[14:12] = 3'b111; end
      2: r[6:0] = 7'h07;
      default: r[6:0] = 7'h27;
    endcase
    if (r[6:0] != 7'h57)
      case ($urandom_range(0, 3))
        0: r[14:12] = 3'd0;
        1: r[14:12] = 3'd5;
        2: r[14:12] = 3'd6;
        default: r[14:12] = 3'd7;
      endcase
    return r;
  endfunction

  function automatic logic [31:0] rand_any();
    logic [31:0] r;
    r = rand_legal();
    case ($urandom_range(0, 4))
      0: r[6:0] = 7'h33;
      1: begin r[6:0] = 7'h07; r[14:12] = 3'(1 + $urandom_range(0, 3)); end
      default: ;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    chk("occupancy", 64'(occupancy), 64'(mq.size()));
    chk("insn_ready", 64'(insn_ready), 64'(rst_n && (mq.size() != DEPTH + 1)));
    if (mq.size() > 0) begin
      chk("fields", {opcode_mjr, opcode_mnr, dest, src_1, src_2, width, mop, mew, nf,
                     vtype_11, vtype_10, cfg_type, vm, funct6}, m_fields(mq[0]));
      chk("class", 64'(insn_class), 64'(m_class(mq[0])));
      chk("illegal", 64'(illegal), 64'(FLAG_EN && m_illegal(mq[0])));
    end
    if (!rst_n)
      chk("reset_zero", {opcode_mjr, opcode_mnr, dest, src_1, src_2, width, mop, mew, nf,
                         vtype_11, vtype_10, cfg_type, vm, funct6, insn_class, illegal,
                         out_valid, occupancy}, 64'd0);
  endtask

  // One clock: drive inputs, advance the reference across the edge, compare.
  task automatic cycle(input bit v, input logic [31:0] ins, input bit rdy, input bit fl,
                       input bit rst = 1'b1);
    bit acc, pp;
    insn_valid = v; insn = ins; out_ready = rdy; flush = fl; rst_n = rst;
    acc = rst && v && (mq.size() != DEPTH + 1);
    pp  = (mq.size() > 0) && rdy;
    @(posedge clk); #1;
    if (!rst || fl) mq.delete();
    else begin
      if (pp) void'(mq.pop_front());
      if (acc && (FLAG_EN || !m_illegal(ins))) mq.push_back(ins);
    end
    check_state();
  endtask

  initial begin
    logic [31:0] vset, ldbad;
    rst_n = 1'b0; flush = 1'b0; insn_valid = 1'b0; insn = '0; out_ready = 1'b0;
    #1;
    cycle(1'b1, rand_legal(), 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    cycle(1'b1, 32'h02208057, 1'b1, 1'b0);
    chk("vadd_class", 64'(insn_class), 64'd0);
    chk("vadd_dest", 64'(dest), 64'd0);
    chk("vadd_src1", 64'(src_1), 64'd1);
    chk("vadd_src2", 64'(src_2), 64'd2);
    chk("vadd_funct6", 64'(funct6), 64'd0);
    chk("vadd_vm", 64'(vm), 64'd1);
    cycle(1'b0, '0, 1'b1, 1'b0);

    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, rand_legal(), 1'b0, 1'b0);
    chk("full_occ", 64'(occupancy), 64'(DEPTH + 1));
    chk("full_ready", 64'(insn_ready), 64'd0);
    cycle(1'b1, rand_legal(), 1'b0, 1'b0);
    cycle(1'b1, rand_legal(), 1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    for (int i = 0; i < 3 * DEPTH; i++) cycle(1'b1, rand_legal(), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    vset  = {1'b0, 11'h0C0, 5'd10, 3'b111, 5'd5, 7'h57};
    ldbad = {3'd0, 1'b0, 2'b00, 1'b1, 5'd0, 5'd1, 3'b010, 5'd2, 7'h07};
    cycle(1'b1, vset, 1'b0, 1'b0);
    chk("vset_class", 64'(insn_class), 64'd3);
    cycle(1'b1, ldbad, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, rand_legal(), 1'b0, 1'b0);
    cycle(1'b1, rand_legal(), 1'b1, 1'b1);
    cycle(1'b1, rand_legal(), 1'b0, 1'b0);
    cycle(1'b1, rand_legal(), 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0);

    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), rand_any(), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 29) == 0));

    for (int i = 0; i < 3; i++) cycle(1'b1, rand_legal(), 1'b0, 1'b0);
    cycle(1'b1, rand_legal(), 1'b1, 1'b0, 1'b0);
    cycle(1'b1, rand_legal(), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
